// File: rtl/shift_rx_deser.sv
// -----------------------------------------------------------------------------
// shift_rx_deser
//
// Serial-to-parallel receiver that sits after the shift_reg stage. It samples
// the bit that shift_reg drives on its LSB and rebuilds WIDTH-bit words, least
// significant bit first. Each finished word goes into a small first-word-
// fall-through FIFO, which the consumer drains with a valid/ready handshake.
// If a word finishes while the FIFO is full and nothing is popped on that edge,
// the word is dropped and the sticky overflow flag is set.
//
// Parameters
//   WIDTH       word width in bits; also the number of serial bits per word
//   DEPTH       FIFO depth in words (power of two, at least 2)
//
// Ports
//   clock       system clock, all state changes on the rising edge
//   reset       synchronous, active-high; overrides every other input
//   ser_valid   ser_in carries a valid bit this cycle
//   ser_in      serial data bit (shift_reg d_out[0])
//   frame_start current bit is bit 0 of a new word (a partial word is dropped)
//   d_out       head-of-FIFO word; reads 0 while the FIFO is empty
//   out_valid   FIFO not empty
//   out_ready   consumer takes d_out on this edge
//   overflow    sticky; set when a completed word was dropped
//   bit_count   bits collected in the current partial word
//   fifo_count  words currently held in the FIFO (0..DEPTH)
// -----------------------------------------------------------------------------
module shift_rx_deser #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    // Derived widths. They are parameters only so that they can size the
    // ports; they are not meant to be overridden.
    parameter int BCW   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_valid,
    input  logic             ser_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [BCW-1:0]   bit_count,
    output logic [CW-1:0]    fifo_count
);

    localparam int PW = $clog2(DEPTH);

    // ---------------------------------------------------------------------
    // Word assembly
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] asm_reg;
    logic [WIDTH-1:0] asm_d;
    logic [WIDTH-1:0] asm_shift;
    logic [WIDTH-1:0] asm_fresh;
    logic [BCW-1:0]   bit_count_d;
    logic [WIDTH-1:0] word_val;
    logic             word_done;

    always_comb begin
        // New bits enter at the MSB and walk down, so after WIDTH shifts the
        // first bit received sits in bit 0.
        asm_shift            = asm_reg >> 1;
        asm_shift[WIDTH-1]   = ser_in;

        // A frame_start bit begins a word from scratch: older partial bits
        // are cleared rather than shifted along.
        asm_fresh            = '0;
        asm_fresh[WIDTH-1]   = ser_in;

        asm_d       = asm_reg;
        bit_count_d = bit_count;
        word_val    = asm_shift;
        word_done   = 1'b0;

        if (ser_valid) begin
            if (frame_start) begin
                asm_d    = asm_fresh;
                word_val = asm_fresh;
                // With one-bit words, the frame_start bit is itself a word.
                if (WIDTH == 1) begin
                    word_done   = 1'b1;
                    bit_count_d = '0;
                end else begin
                    bit_count_d = BCW'(1);
                end
            end else if (bit_count == BCW'(WIDTH - 1)) begin
                asm_d       = asm_shift;
                word_val    = asm_shift;
                word_done   = 1'b1;
                bit_count_d = '0;
            end else begin
                asm_d       = asm_shift;
                bit_count_d = bit_count + BCW'(1);
            end
        end else if (frame_start) begin
            asm_d       = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_reg   <= '0;
            bit_count <= '0;
        end else begin
            asm_reg   <= asm_d;
            bit_count <= bit_count_d;
        end
    end

    // ---------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && out_ready;

    // A full FIFO still accepts a word when a pop frees a slot on the same
    // edge; only a push into a full FIFO with no pop is dropped.
    assign push = word_done && (!fifo_full || pop);
    assign drop = word_done && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; the pointers and count are what define the
    // contents, and d_out is masked while empty.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= word_val;
        end
    end

    assign out_valid = !fifo_empty;
    assign d_out     = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_shift_rx_deser.sv
module tb_shift_rx_deser;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       ser_valid;
    logic       ser_in;
    logic       frame_start;
    logic [7:0] d_out;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [2:0] bit_count;
    logic [2:0] fifo_count;

    shift_rx_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .ser_valid   (ser_valid),
        .ser_in      (ser_in),
        .frame_start (frame_start),
        .d_out       (d_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .bit_count   (bit_count),
        .fifo_count  (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of received bits and a queue of words.
    logic       m_bits [$];
    logic [7:0] m_fifo [$];
    logic       m_ovf;

    logic [7:0] dut_pops [$];
    logic [7:0] exp_pops [$];
    int         peak;

    typedef struct {
        logic       r, v, s, f, rd;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ebc;
        logic [2:0] efc;
        logic       eovf;
    } vec_t;

    vec_t vec [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, v, s, f, rd);
        logic       do_pop;
        logic       do_push;
        logic [7:0] w;
        if (r) begin
            m_bits.delete();
            m_fifo.delete();
            m_ovf = 1'b0;
            return;
        end
        do_pop  = (m_fifo.size() > 0) && rd;
        do_push = 1'b0;
        w       = '0;
        if (v) begin
            if (f) m_bits.delete();
            m_bits.push_back(s);
            if (m_bits.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
                m_bits.delete();
                do_push = 1'b1;
            end
        end else if (f) begin
            m_bits.delete();
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (do_push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else                       m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model();
        check("model out_valid",  int'(out_valid),  int'(m_fifo.size() > 0));
        check("model d_out",      int'(d_out),      (m_fifo.size() > 0) ? int'(m_fifo[0]) : 0);
        check("model bit_count",  int'(bit_count),  m_bits.size());
        check("model fifo_count", int'(fifo_count), m_fifo.size());
        check("model overflow",   int'(overflow),   int'(m_ovf));
    endtask

    // Drive one cycle: inputs set after the previous edge, outputs checked
    // 1 ns after this edge.
    task automatic apply(input logic r, v, s, f, rd);
        reset = r; ser_valid = v; ser_in = s; frame_start = f; out_ready = rd;
        if (!r && out_valid && rd) dut_pops.push_back(d_out);
        model_step(r, v, s, f, rd);
        @(posedge clock);
        #1;
        compare_model();
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs, input logic rd, input logic rd_last);
        for (int i = 0; i < WIDTH; i++)
            apply(1'b0, 1'b1, w[i], (i == 0) ? fs : 1'b0, (i == WIDTH - 1) ? rd_last : rd);
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, rd);
    endtask

    task automatic check_pops(input string name);
        check({name, " count"}, dut_pops.size(), exp_pops.size());
        for (int i = 0; i < exp_pops.size(); i++) begin
            if (i < dut_pops.size()) check(name, int'(dut_pops[i]), int'(exp_pops[i]));
        end
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
        m_ovf = 1'b0;
        peak  = 0;

        // Reset for 2 cycles, then 8'h55 back to back, then one pop cycle.
        pat = 8'h55;
        for (int k = 0; k < 2; k++)
            vec[k] = '{r:1'b1, v:1'b0, s:1'b0, f:1'b0, rd:1'b0,
                       ev:1'b0, ed:8'h00, ebc:3'd0, efc:3'd0, eovf:1'b0};
        for (int k = 0; k < 8; k++)
            vec[2+k] = '{r:1'b0, v:1'b1, s:pat[k], f:1'b0, rd:1'b1,
                         ev:(k == 7), ed:(k == 7) ? 8'h55 : 8'h00,
                         ebc:3'((k + 1) % 8), efc:(k == 7) ? 3'd1 : 3'd0, eovf:1'b0};
        vec[10] = '{r:1'b0, v:1'b0, s:1'b0, f:1'b0, rd:1'b1,
                    ev:1'b0, ed:8'h00, ebc:3'd0, efc:3'd0, eovf:1'b0};

        // Test 1 and 2: table vectors
        for (int k = 0; k < 11; k++) begin
            logic vv, ss;
            vv = vec[k].r ? 1'($urandom_range(1)) : vec[k].v;
            ss = vec[k].r ? 1'($urandom_range(1)) : vec[k].s;
            apply(vec[k].r, vv, ss, vec[k].f, vec[k].rd);
            check($sformatf("vec%0d out_valid", k),  int'(out_valid),  int'(vec[k].ev));
            check($sformatf("vec%0d d_out", k),      int'(d_out),      int'(vec[k].ed));
            check($sformatf("vec%0d bit_count", k),  int'(bit_count),  int'(vec[k].ebc));
            check($sformatf("vec%0d fifo_count", k), int'(fifo_count), int'(vec[k].efc));
            check($sformatf("vec%0d overflow", k),   int'(overflow),   int'(vec[k].eovf));
        end

        // Test 3: gapped 8'hCC
        dut_pops.delete();
        peak = 0;
        pat = 8'hCC;
        for (int i = 0; i < WIDTH; i++) begin
            apply(1'b0, 1'b1, pat[i], 1'b0, 1'b1);
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 2) check("gap bit_count hold", int'(bit_count), 3);
        end
        idle(2, 1'b1);
        exp_pops = '{8'hCC};
        check_pops("gapped pops");
        check("gapped peak", peak, 1);

        // Test 4: overflow
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        dut_pops.delete();
        for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0, 1'b0);
        check("ovf fifo_count", int'(fifo_count), 4);
        check("ovf flag", int'(overflow), 1);
        idle(5, 1'b1);
        exp_pops = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_pops("ovf drain");
        check("ovf sticky", int'(overflow), 1);

        // Test 5: push and pop while full
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        dut_pops.delete();
        for (int w = 8'h10; w <= 8'h13; w++) send_word(8'(w), 1'b0, 1'b0, 1'b0);
        send_word(8'h14, 1'b0, 1'b0, 1'b1);
        check("full push/pop fifo_count", int'(fifo_count), 4);
        check("full push/pop overflow", int'(overflow), 0);
        idle(5, 1'b1);
        exp_pops = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_pops("full push/pop drain");

        // Test 6: resynchronisation
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        dut_pops.delete();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_word(8'hFF, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        exp_pops = '{8'hFF};
        check_pops("frame_start pops");

        dut_pops.delete();
        pat = 8'h3C;
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, pat[i], 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("reset mid-word bit_count", int'(bit_count), 0);
        send_word(8'hA5, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
        exp_pops = '{8'hA5};
        check_pops("reset resync pops");

        // Randomised run against the model
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom_range(99) == 0),
                  1'($urandom_range(1)),
                  1'($urandom_range(1)),
                  ($urandom_range(19) == 0),
                  ($urandom_range(2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rx_deser.md
Name: shift_rx_deser

Overview:
Downstream consumer of the shift_reg stage. Samples the serial bit that shift_reg presents on its LSB (d_out[0]) and reassembles WIDTH-bit words, LSB first. Completed words are buffered in a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake. FIFO overruns are flagged by a sticky overflow bit.

Parameters:
WIDTH, 8, word width in bits; also the number of serial bits per word
DEPTH, 4, FIFO depth in words; power of 2, minimum 2

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
ser_valid  input  1  ser_in carries a valid bit this cycle
ser_in  input  1  serial data bit, driven from shift_reg d_out[0]
frame_start  input  1  current bit is bit 0 of a new word
d_out  output  WIDTH  head-of-FIFO word
out_valid  output  1  FIFO not empty; d_out is valid
out_ready  input  1  consumer accepts d_out this cycle
overflow  output  1  sticky; a completed word was dropped
bit_count  output  clog2(WIDTH)  bits collected in the current partial word
fifo_count  output  clog2(DEPTH)+1  words held in the FIFO

Behaviour:
- Reset (synchronous, active-high), wins over all other inputs:
  - clears the assembly register, bit_count, the FIFO pointers, fifo_count and overflow.
  - outputs after a reset edge: d_out=0, out_valid=0, overflow=0, bit_count=0, fifo_count=0.
- Assembly, on each edge with ser_valid=1:
  - asm <= {ser_in, asm[WIDTH-1:1]}.
  - bit_count <= bit_count+1.
- Cycles with ser_valid=0 hold asm and bit_count unchanged. Gaps of any length are allowed.
- Word completion, on an edge with ser_valid=1 and bit_count==WIDTH-1:
  - completed word = {ser_in, asm[WIDTH-1:1]}.
  - the word is pushed into the FIFO on that same edge.
  - bit_count wraps to 0.
- frame_start with ser_valid=1:
  - any partial word is discarded.
  - the current bit is stored as bit 0 of the new word, so bit_count becomes 1.
  - the discarded partial is never pushed.
- frame_start with ser_valid=0: clears bit_count and asm; nothing is pushed.
- WIDTH=1 special case: every valid bit completes a word.
- FIFO, first-word-fall-through:
  - latency: a word completing at edge N gives out_valid=1 and d_out=word in the cycle after edge N.
  - pop occurs on an edge with out_valid=1 and out_ready=1; the next word, or 0 if the FIFO becomes empty, appears after that edge.
  - out_ready while out_valid=0 is ignored; no underflow is possible.
  - d_out reads 0 whenever out_valid=0.
- Simultaneous push and pop:
  - both take effect on the same edge and fifo_count is unchanged.
  - this also applies when the FIFO is full: the push is accepted because a slot frees on the same edge.
- Push while full without a pop: the word is dropped, FIFO contents are unchanged, and overflow is set to 1. overflow stays 1 until reset.
- Pointers wrap modulo DEPTH. fifo_count is in the range 0..DEPTH.
- Reset during a partial word or with a non-empty FIFO discards everything. Collection restarts from bit 0 after reset.

Test Plan:
1. Reset: reset=1 for 2 cycles with random ser_in/ser_valid -> d_out=8'h00, out_valid=0, overflow=0, bit_count=0, fifo_count=0.
2. Back-to-back bits: out_ready=1; send 8'h55 LSB first (1,0,1,0,1,0,1,0) with ser_valid=1 on 8 consecutive cycles -> out_valid=1 with d_out=8'h55 exactly one cycle after the 8th edge; popped next edge, then out_valid=0.
3. Gapped bits: send 8'h CC with ser_valid=1 on every other cycle -> bit_count holds during gaps; d_out=8'hCC once; fifo_count peaks at 1.
4. Overflow: out_ready=0; send words 8'h01..8'h05 -> fifo_count=4 and overflow=1 after the 5th word completes. Then out_ready=1 -> pops 01,02,03,04 in order; overflow stays 1.
5. Push and pop while full: fill with 8'h10..8'h13; hold out_ready=1 on the edge that completes 8'h14 -> fifo_count stays 4, overflow=0, drain order 11,12,13,14.
6. Resynchronisation:
   - send 3 bits of garbage, then 8'hFF with frame_start=1 on its first bit -> only 8'hFF is output.
   - then reset after 4 bits of a word, and send 8'hA5 -> only 8'hA5 is output.
